// File: rtl/div3_pkg.sv
// Shared mod-3 residue definitions for the serial and combinational divisibility checkers.
package div3_pkg;

  typedef enum logic [1:0] {
    MOD0 = 2'd0,
    MOD1 = 2'd1,
    MOD2 = 2'd2
  } mod3_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Residue after appending bit b below the bits already seen: (2*r + b) mod 3.
  function automatic mod3_t mod3_step(mod3_t r, logic b);
    mod3_t nxt;
    case (r)
      MOD0:    nxt = b ? MOD1 : MOD0;
      MOD1:    nxt = b ? MOD0 : MOD2;
      MOD2:    nxt = b ? MOD2 : MOD1;
      default: nxt = MOD0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/div3_serial_checker.sv
// Bit-serial divisibility-by-3 checker with valid/ready on both sides, one word in flight.
// Build option: define DIV3_REM_OUT_EN to expose the residue on out_rem.
module div3_serial_checker
  import div3_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_div
`ifdef DIV3_REM_OUT_EN
  ,
  output logic [1:0]        out_rem
`endif
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  mod3_t             res_q, res_d;
  mod3_t             res_next;
  logic              div_q, div_d;
`ifdef DIV3_REM_OUT_EN
  logic [1:0]        rem_q, rem_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      res_q   <= MOD0;
      div_q   <= 1'b0;
`ifdef DIV3_REM_OUT_EN
      rem_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      div_q   <= div_d;
`ifdef DIV3_REM_OUT_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign res_next = mod3_step(res_q, shreg_q[DATA_W-1]);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    div_d   = div_q;
`ifdef DIV3_REM_OUT_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = CntW'(DATA_W);
          res_d   = MOD0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = res_next;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CntW'(1);
        // Last bit: capture the result so it is stable for the whole of DONE.
        if (cnt_q == CntW'(1)) begin
          state_d = DONE;
          div_d   = (res_next == MOD0);
`ifdef DIV3_REM_OUT_EN
          rem_d   = res_next;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_div   = div_q;
`ifdef DIV3_REM_OUT_EN
  assign out_rem   = rem_q;
`endif

endmodule

// File: tb/tb_div3_serial_checker.sv
// Directed bench for div3_serial_checker at DATA_W = 8, 1 and 13; out_rem checks follow
// DIV3_REM_OUT_EN.
module tb_div3_serial_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv8, ir8, ov8, or8, od8;
  logic [7:0]  id8;
  logic        iv1, ir1, ov1, or1, od1;
  logic [0:0]  id1;
  logic        iv13, ir13, ov13, or13, od13;
  logic [12:0] id13;
`ifdef DIV3_REM_OUT_EN
  logic [1:0]  rm8, rm1, rm13;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  div3_serial_checker #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_div(od8)
`ifdef DIV3_REM_OUT_EN
    , .out_rem(rm8)
`endif
  );

  div3_serial_checker #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_div(od1)
`ifdef DIV3_REM_OUT_EN
    , .out_rem(rm1)
`endif
  );

  div3_serial_checker #(.DATA_W(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13), .in_data(id13),
    .out_valid(ov13), .out_ready(or13), .out_div(od13)
`ifdef DIV3_REM_OUT_EN
    , .out_rem(rm13)
`endif
  );

  function automatic logic get_ov(int w);
    case (w)
      1:       return ov1;
      13:      return ov13;
      default: return ov8;
    endcase
  endfunction

  function automatic logic get_ir(int w);
    case (w)
      1:       return ir1;
      13:      return ir13;
      default: return ir8;
    endcase
  endfunction

  function automatic logic get_od(int w);
    case (w)
      1:       return od1;
      13:      return od13;
      default: return od8;
    endcase
  endfunction

`ifdef DIV3_REM_OUT_EN
  function automatic logic [1:0] get_rm(int w);
    case (w)
      1:       return rm1;
      13:      return rm13;
      default: return rm8;
    endcase
  endfunction
`endif

  task automatic drive(input int w, input logic v, input logic [12:0] d, input logic r);
    case (w)
      1:       begin iv1 = v;  id1 = d[0:0]; or1 = r;  end
      13:      begin iv13 = v; id13 = d;     or13 = r; end
      default: begin iv8 = v;  id8 = d[7:0]; or8 = r;  end
    endcase
  endtask

  // Entered and left on a negedge. hold > 0 keeps out_ready low for that many DONE cycles;
  // mess scrambles in_data and in_valid while the word is being shifted.
  task automatic run_word(input string tag, input int w, input logic [12:0] x,
                          input logic exp_div, input logic [1:0] exp_rem,
                          input int hold, input bit mess);
    int   edges;
    bit   seen;
    chk({tag, " in_ready idle"}, get_ir(w), 1'b1);
    drive(w, 1'b1, x, hold == 0);
    @(posedge clk);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 64) begin
      @(negedge clk);
      if (get_ov(w)) begin
        seen = 1'b1;
      end else begin
        if (mess) drive(w, 1'($urandom), ~x, hold == 0);
        else      drive(w, 1'b0, x, hold == 0);
        @(posedge clk);
        edges++;
      end
    end
    if (!seen) begin
      n_fail++;
      $error("FAIL %s timeout: no out_valid within %0d edges", tag, edges);
    end
    chk({tag, " result seen"}, seen, 1'b1);
    if (!seen) return;
    drive(w, 1'b0, x, hold == 0);
    chk({tag, " latency"}, edges + 1, w + 1);
    chk({tag, " out_div"}, get_od(w), exp_div);
`ifdef DIV3_REM_OUT_EN
    chk({tag, " out_rem"}, get_rm(w), exp_rem);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " held out_valid"}, get_ov(w), 1'b1);
      chk({tag, " held out_div"}, get_od(w), exp_div);
      chk({tag, " held in_ready"}, get_ir(w), 1'b0);
`ifdef DIV3_REM_OUT_EN
      chk({tag, " held out_rem"}, get_rm(w), exp_rem);
`endif
    end
    drive(w, 1'b0, x, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " in_ready after handshake"}, get_ir(w), 1'b1);
    chk({tag, " out_valid after handshake"}, get_ov(w), 1'b0);
  endtask

  initial begin
    int spurious;
    int v;
    rst = 1'b1;
    drive(8, 1'b0, 13'd0, 1'b1);
    drive(1, 1'b0, 13'd0, 1'b1);
    drive(13, 1'b0, 13'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready w8", ir8, 1'b1);
    chk("reset out_valid w8", ov8, 1'b0);
    chk("reset out_div w8", od8, 1'b0);
    chk("reset in_ready w1", ir1, 1'b1);
    chk("reset out_valid w1", ov1, 1'b0);
    chk("reset out_valid w13", ov13, 1'b0);
`ifdef DIV3_REM_OUT_EN
    chk("reset out_rem w8", rm8, 2'd0);
`endif

    run_word("zero", 8, 13'd0, 1'b1, 2'd0, 0, 1'b0);
    run_word("d255", 8, 13'd255, 1'b1, 2'd0, 0, 1'b0);
    run_word("d100", 8, 13'd100, 1'b0, 2'd1, 0, 1'b0);
    run_word("d200", 8, 13'd200, 1'b0, 2'd2, 0, 1'b0);
    run_word("d3", 8, 13'd3, 1'b1, 2'd0, 0, 1'b0);
    run_word("d1", 8, 13'd1, 1'b0, 2'd1, 0, 1'b0);

    // Back-pressure, then the next word on the very next edge.
    run_word("hold200", 8, 13'd200, 1'b0, 2'd2, 5, 1'b0);
    run_word("after_hold", 8, 13'd5, 1'b0, 2'd2, 0, 1'b0);

    // Reset during SHIFT cycle 4 of the word 7.
    drive(8, 1'b1, 13'd7, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 13'd7, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", ir8, 1'b1);
    chk("abort out_valid", ov8, 1'b0);
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov8) spurious++;
    end
    chk("abort no result", spurious, 0);
    run_word("d6", 8, 13'd6, 1'b1, 2'd0, 0, 1'b0);

    // Input noise during SHIFT must not touch the accepted word.
    run_word("mess100", 8, 13'd100, 1'b0, 2'd1, 0, 1'b1);
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov8 || !ir8) spurious++;
    end
    chk("mess no extra accept", spurious, 0);
    run_word("mess7", 8, 13'd7, 1'b0, 2'd1, 0, 1'b1);

    for (int x = 0; x < 256; x++) begin
      run_word("sweep8", 8, 13'(x), 1'((x % 3) == 0), 2'(x % 3), 0, 1'b0);
    end

    run_word("w1_0", 1, 13'd0, 1'b1, 2'd0, 0, 1'b0);
    run_word("w1_1", 1, 13'd1, 1'b0, 2'd1, 0, 1'b0);

    run_word("w13_max", 13, 13'd8191, 1'b0, 2'd1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 8191));
      run_word("rand13", 13, 13'(v), 1'((v % 3) == 0), 2'(v % 3), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div3_serial_checker.md
Name: div3_serial_checker

Overview:
- Sequential divisibility-by-3 stage that accepts one DATA_W-bit word per input handshake.
- Scans the word one bit per clock, MSB first, through a mod-3 residue state machine.
- Emits a divisible flag and the residue through an output handshake.
- Sits beside the combinational mod-3 checker as its area-optimised, multi-cycle counterpart. It uses valid/ready on both sides so it can sit directly in a streaming datapath.

Parameters:
- DATA_W, default 8: width of the input word in bits; legal range is 1 and above.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  DATA_W  word to test, unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_div  output  1  1 when in_data mod 3 == 0.
- out_rem  output  2  in_data mod 3 (0, 1 or 2); present only with DIV3_REM_OUT_EN.

Behaviour:
- Reset (rst high at a clock edge):
  - state returns to IDLE.
  - in_ready=1, out_valid=0, out_div=0, out_rem=0.
  - The shift register, bit counter and residue clear to 0 / MOD0.
  - Reset overrides every other input in the same cycle. A word in flight is discarded and produces no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load the shift register with in_data, load the counter with DATA_W, set residue=MOD0, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle consumes the current MSB b of the shift register and sets residue = (2*residue + b) mod 3. The step mapping is:
    - MOD0: b=0 gives MOD0, b=1 gives MOD1.
    - MOD1: b=0 gives MOD2, b=1 gives MOD0.
    - MOD2: b=0 gives MOD1, b=1 gives MOD2.
  - Each cycle shifts the register left by one and decrements the counter.
  - When the counter reaches 1 in this cycle, go to DONE.
  - SHIFT lasts exactly DATA_W cycles.
- DONE:
  - out_valid=1, out_div = (residue==MOD0), out_rem = residue encoding.
  - The outputs are registered and held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Latency and throughput:
  - out_valid rises DATA_W+1 edges after the accepting edge.
  - The earliest next acceptance is the edge after the output handshake.
  - Throughput is therefore at most one word per DATA_W+2 cycles. There is no overlap between words.
- in_data is sampled only at the accepting edge. Later changes to in_data have no effect on the word being processed.
- in_valid is ignored outside IDLE.
- out_div and out_rem are undefined-free: they hold their last values while out_valid=0, and are 0 after reset.
- DATA_W=1 is legal: SHIFT lasts one cycle, and out_div = ~in_data[0].
- Counter width is $clog2(DATA_W+1). The counter does not wrap; a counter value of 0 never occurs in SHIFT.

Optional Feature:
- Macro: DIV3_REM_OUT_EN.
- Defined: the out_rem port exists and carries the residue (0, 1 or 2; 3 never appears).
- Undefined: out_rem is absent, and the residue register is internal only. out_div behaviour and all timing are unchanged.

Decomposition:
- Package div3_pkg:
  - typedef enum logic [1:0] mod3_t {MOD0, MOD1, MOD2}.
  - function mod3_step(mod3_t r, logic b) returning mod3_t.
  - typedef enum state_t {IDLE, SHIFT, DONE}.
- The combinational checker reuses mod3_t and mod3_step, so both blocks share one residue definition.
- No sub-module is needed: the FSM, counter and shift register live in one module. mod3_step is a package function rather than an instance.

Test Plan:
- Accept 8'd0 with out_ready=1: out_valid is seen 9 edges after acceptance with out_div=1, out_rem=0. in_ready is high again on the edge after the output handshake.
- Sequence 8'd255, 8'd100, 8'd200, 8'd3, 8'd1 with checks of out_div/out_rem:
  - 255 gives 1/0.
  - 100 gives 0/1.
  - 200 gives 0/2.
  - 3 gives 1/0.
  - 1 gives 0/1.
- Hold out_ready=0 for 5 cycles in DONE: out_valid, out_div and out_rem stay stable and in_ready stays 0. Raising out_ready completes the handshake, and the next word is accepted the following edge.
- Assert rst for one cycle mid-SHIFT (cycle 4 of 8): next cycle in_ready=1 and out_valid=0, and no result appears for the aborted word. A fresh 8'd6 then yields out_div=1.
- Change in_data and toggle in_valid during SHIFT: the result matches the originally accepted word, and no extra acceptance occurs.
- Exhaustive sweep of 0..255, plus DATA_W=1 (inputs 0 and 1) and DATA_W=13 random values: out_div==(x%3==0) and out_rem==x%3, with the latency checked against DATA_W+1.
